// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART RX frame controller.
// Sample/strobe offsets are expressed relative to half the effective prescale.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned PrescaleDefault = 8;

    // Majority taps land at P/2-2, P/2-1 and P/2.
    localparam int unsigned SampleLeadEarly = 2;
    localparam int unsigned SampleLeadMid   = 1;
    localparam int unsigned SampleLeadLate  = 0;

    localparam int unsigned VoteLag   = 1;
    localparam int unsigned ShiftLag  = 2;
    localparam int unsigned ParCapLag = 3;

    function automatic int unsigned norm_prescale(input int unsigned p);
        return (p == 16 || p == 32) ? p : PrescaleDefault;
    endfunction

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Pin-side and parity-checker signals of the UART RX frame controller.
interface uart_rx_frame_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
);

    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  PAR_EN;
    logic                  par_err;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  sampled_bit;
    logic                  par_chk_en;
    logic                  data_valid;
    logic                  par_err_flag;
    logic                  stp_err;
    logic                  strt_glitch;
    logic                  busy;

    modport master (
        input  RX_IN, PRESCALE, PAR_EN, par_err,
        output P_DATA, sampled_bit, par_chk_en, data_valid, par_err_flag, stp_err,
               strt_glitch, busy
    );

    modport slave (
        output RX_IN, PRESCALE, PAR_EN, par_err,
        input  P_DATA, sampled_bit, par_chk_en, data_valid, par_err_flag, stp_err,
               strt_glitch, busy
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-tap majority voter for the RX line.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit
);

    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] half;
    logic [2:0]            taps_q;
    logic                  sampled_q;

    assign half        = prescale >> 1;
    assign edge_cnt    = edge_cnt_q;
    assign sampled_bit = sampled_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            taps_q     <= '0;
            sampled_q  <= 1'b0;
        end else if (clr) begin
            edge_cnt_q <= '0;
        end else if (en) begin
            edge_cnt_q <= (edge_cnt_q == prescale - PRESCALE_W'(1)) ? '0
                                                                     : edge_cnt_q + 1'b1;
            if (edge_cnt_q == half - PRESCALE_W'(SampleLeadEarly)) taps_q[0] <= rx_in;
            if (edge_cnt_q == half - PRESCALE_W'(SampleLeadMid))   taps_q[1] <= rx_in;
            if (edge_cnt_q == half - PRESCALE_W'(SampleLeadLate))  taps_q[2] <= rx_in;
            if (edge_cnt_q == half + PRESCALE_W'(VoteLag))         sampled_q <= maj3(taps_q);
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start/data/parity/stop sequencing, LSB-first
// deserialization and one-cycle result strobes.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input logic                  CLK,
    input logic                  RST,
    uart_rx_frame_ctrl_if.master bus
);

    localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

    rx_state_e             state_q;
    logic [BitCntW-1:0]    bit_cnt_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_fail_q;
    logic                  par_chk_en_q;
    logic                  data_valid_q;
    logic                  par_err_flag_q;
    logic                  stp_err_q;
    logic                  strt_glitch_q;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic                  sampled_bit;
    logic                  start_det;
    logic                  bit_end;
    logic                  at_vote;
    logic                  at_shift;
    logic                  at_par_cap;

    assign start_det  = (state_q == StIdle) && !bus.RX_IN;
    assign half       = prescale_q >> 1;
    assign bit_end    = edge_cnt == prescale_q - PRESCALE_W'(1);
    assign at_vote    = edge_cnt == half + PRESCALE_W'(VoteLag);
    assign at_shift   = edge_cnt == half + PRESCALE_W'(ShiftLag);
    assign at_par_cap = edge_cnt == half + PRESCALE_W'(ParCapLag);

    uart_rx_sampler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .en         (state_q != StIdle),
        .clr        (start_det),
        .rx_in      (bus.RX_IN),
        .prescale   (prescale_q),
        .edge_cnt   (edge_cnt),
        .sampled_bit(sampled_bit)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            p_data_q       <= '0;
            prescale_q     <= PRESCALE_W'(PrescaleDefault);
            par_en_q       <= 1'b0;
            par_fail_q     <= 1'b0;
            par_chk_en_q   <= 1'b0;
            data_valid_q   <= 1'b0;
            par_err_flag_q <= 1'b0;
            stp_err_q      <= 1'b0;
            strt_glitch_q  <= 1'b0;
        end else begin
            par_chk_en_q   <= 1'b0;
            data_valid_q   <= 1'b0;
            par_err_flag_q <= 1'b0;
            stp_err_q      <= 1'b0;
            strt_glitch_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_det) begin
                        state_q    <= StStart;
                        prescale_q <= PRESCALE_W'(norm_prescale(32'(bus.PRESCALE)));
                        par_en_q   <= bus.PAR_EN;
                        par_fail_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        if (sampled_bit) begin
                            strt_glitch_q <= 1'b1;
                            state_q       <= StIdle;
                        end else begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                StData: begin
                    if (at_shift) p_data_q <= {sampled_bit, p_data_q[DATA_WIDTH-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == LastBit) begin
                            state_q <= par_en_q ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    // Set one edge early so the strobe is high while edge_cnt == P/2+2.
                    if (at_vote)    par_chk_en_q <= 1'b1;
                    if (at_par_cap) par_fail_q   <= bus.par_err;
                    if (bit_end)    state_q      <= StStop;
                end
                StStop: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        if (!sampled_bit) begin
                            stp_err_q <= 1'b1;
                        end else if (par_fail_q) begin
                            par_err_flag_q <= 1'b1;
                        end else begin
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.P_DATA       = p_data_q;
    assign bus.sampled_bit  = sampled_bit;
    assign bus.par_chk_en   = par_chk_en_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.par_err_flag = par_err_flag_q;
    assign bus.stp_err      = stp_err_q;
    assign bus.strt_glitch  = strt_glitch_q;
    assign bus.busy         = state_q != StIdle;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed self-checking bench for uart_rx_frame_ctrl with an even-parity checker model.
module tb_uart_rx_frame_ctrl;

    logic CLK;
    logic RST;
    int   total;
    int   bad;
    int   cyc;
    bit   mon_en;
    int   n_dv, n_pef, n_se, n_sg, n_pce, n_multi;
    int   dv_cyc;
    int   start_cyc;
    bit   par_pending;
    logic [7:0] dv_q[$];

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx_frame_ctrl #(
        .DATA_WIDTH(8),
        .PRESCALE_W(6)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Parity checker model: answers the cycle after par_chk_en.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        #1;
        bus.par_err = par_pending;
        par_pending = 1'b0;
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            if (bus.data_valid === 1'b1) begin
                n_dv++;
                dv_cyc = cyc;
                dv_q.push_back(bus.P_DATA);
            end
            if (bus.par_err_flag === 1'b1) n_pef++;
            if (bus.stp_err === 1'b1) n_se++;
            if (bus.strt_glitch === 1'b1) n_sg++;
            if (bus.par_chk_en === 1'b1) begin
                n_pce++;
                par_pending = ^{bus.P_DATA, bus.sampled_bit};
            end
            if ((int'(bus.data_valid === 1'b1) + int'(bus.par_err_flag === 1'b1)
                 + int'(bus.stp_err === 1'b1) + int'(bus.strt_glitch === 1'b1)) > 1) n_multi++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_counts();
        n_dv = 0; n_pef = 0; n_se = 0; n_sg = 0; n_pce = 0;
        dv_cyc = -1;
        dv_q.delete();
    endtask

    // Drives one frame LSB-first; glitch_idx flips the centre sample of that frame bit.
    task automatic send_frame(input logic [7:0] data, input bit par_en, input bit par_bit,
                              input bit stop_bit, input int ps, input int p,
                              input int glitch_idx);
        logic [10:0] fb;
        int          nbits;
        logic        v;
        bus.PRESCALE = 6'(ps);
        bus.PAR_EN   = par_en;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = data[i];
        if (par_en) begin
            fb[9]  = par_bit;
            fb[10] = stop_bit;
            nbits  = 11;
        end else begin
            fb[9]  = stop_bit;
            nbits  = 10;
        end
        start_cyc = cyc;
        for (int b = 0; b < nbits; b++) begin
            v = fb[b];
            for (int c = 0; c < p; c++) begin
                bus.RX_IN = (b == glitch_idx && c == p / 2) ? ~v : v;
                tick();
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.RX_IN = 1'b1;
        bus.PRESCALE = 6'd8;
        bus.PAR_EN = 1'b0;
        bus.par_err = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus.P_DATA, bus.sampled_bit, bus.par_chk_en, bus.data_valid, bus.par_err_flag,
             bus.stp_err, bus.strt_glitch, bus.busy} !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs: got P_DATA=%h busy=%b dv=%b want all zero",
                     bus.P_DATA, bus.busy, bus.data_valid);
        end
        RST = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_parity_ok();
        clear_counts();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, 8, -1);
        repeat (4) tick();
        total++;
        if (bus.P_DATA !== 8'hA5) begin
            bad++; $display("FAIL par_ok_data: got %h want a5", bus.P_DATA);
        end
        total++;
        if (n_dv !== 1) begin
            bad++; $display("FAIL par_ok_dv_count: got %0d want 1", n_dv);
        end
        total++;
        if (dv_cyc - start_cyc !== 89) begin
            bad++; $display("FAIL par_ok_latency: got %0d want 89", dv_cyc - start_cyc);
        end
        total++;
        if (n_pce !== 1) begin
            bad++; $display("FAIL par_ok_chk_en: got %0d want 1", n_pce);
        end
        total++;
        if (n_pef + n_se + n_sg !== 0) begin
            bad++; $display("FAIL par_ok_other_strobes: got %0d want 0", n_pef + n_se + n_sg);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL par_ok_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_no_parity();
        clear_counts();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, 16, -1);
        repeat (4) tick();
        total++;
        if (n_dv !== 1 || dv_q.size() != 1 || dv_q[0] !== 8'h3C) begin
            bad++; $display("FAIL nopar_dv: got count=%0d want 1 with data 3c", n_dv);
        end
        total++;
        if (n_pce !== 0) begin
            bad++; $display("FAIL nopar_chk_en: got %0d want 0", n_pce);
        end
    endtask

    task automatic test_parity_err();
        clear_counts();
        send_frame(8'h01, 1'b1, 1'b0, 1'b1, 8, 8, -1);
        repeat (4) tick();
        total++;
        if (n_pef !== 1) begin
            bad++; $display("FAIL parerr_flag: got %0d want 1", n_pef);
        end
        total++;
        if (n_dv !== 0) begin
            bad++; $display("FAIL parerr_no_dv: got %0d want 0", n_dv);
        end
        total++;
        if (n_pce !== 1) begin
            bad++; $display("FAIL parerr_chk_en: got %0d want 1", n_pce);
        end
    endtask

    task automatic test_stop_err();
        clear_counts();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 32, 32, -1);
        repeat (4) tick();
        total++;
        if (n_se !== 1) begin
            bad++; $display("FAIL stoperr_flag: got %0d want 1", n_se);
        end
        total++;
        if (n_dv + n_pef !== 0) begin
            bad++; $display("FAIL stoperr_no_dv: got %0d want 0", n_dv + n_pef);
        end
    endtask

    task automatic test_start_glitch();
        clear_counts();
        bus.PRESCALE = 6'd8;
        bus.PAR_EN = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (2) tick();
        bus.RX_IN = 1'b1;
        repeat (12) tick();
        total++;
        if (n_sg !== 1) begin
            bad++; $display("FAIL glitch_flag: got %0d want 1", n_sg);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL glitch_busy: got %b want 0", bus.busy);
        end
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8, 8, -1);
        repeat (4) tick();
        total++;
        if (n_dv !== 1 || dv_q.size() != 1 || dv_q[0] !== 8'h55) begin
            bad++; $display("FAIL glitch_next_frame: got count=%0d P_DATA=%h want 1 with 55",
                            n_dv, bus.P_DATA);
        end
    endtask

    task automatic test_majority();
        clear_counts();
        // Data bit 3 of 0x96 is 0; its centre sample is flipped to 1.
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 16, 16, 4);
        repeat (4) tick();
        total++;
        if (bus.P_DATA !== 8'h96 || n_dv !== 1) begin
            bad++; $display("FAIL majority_data: got %h count=%0d want 96 count=1",
                            bus.P_DATA, n_dv);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8, 8, -1);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8, 8, -1);
        repeat (4) tick();
        total++;
        if (dv_q.size() != 2) begin
            bad++; $display("FAIL b2b_count: got %0d want 2", dv_q.size());
        end else begin
            total++;
            if (dv_q[0] !== 8'h5A || dv_q[1] !== 8'hC3) begin
                bad++; $display("FAIL b2b_data: got %h %h want 5a c3", dv_q[0], dv_q[1]);
            end
        end
    endtask

    task automatic test_prescale_default();
        clear_counts();
        // 0x6B has five ones, so even parity bit is 1; PRESCALE 5 runs as 8.
        send_frame(8'h6B, 1'b1, 1'b1, 1'b1, 5, 8, -1);
        repeat (4) tick();
        total++;
        if (n_dv !== 1 || bus.P_DATA !== 8'h6B || n_pef !== 0) begin
            bad++; $display("FAIL ps_default: got count=%0d P_DATA=%h pef=%0d want 1 6b 0",
                            n_dv, bus.P_DATA, n_pef);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        bus.PRESCALE = 6'd16;
        bus.PAR_EN = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (16) tick();
        bus.RX_IN = 1'b1;
        repeat (40) tick();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy);
        end
        RST = 1'b0;
        tick();
        total++;
        if ({bus.P_DATA, bus.sampled_bit, bus.par_chk_en, bus.data_valid, bus.par_err_flag,
             bus.stp_err, bus.strt_glitch, bus.busy} !== 15'h0) begin
            bad++; $display("FAIL midrst_outputs: got P_DATA=%h busy=%b want all zero",
                            bus.P_DATA, bus.busy);
        end
        RST = 1'b1;
        repeat (200) tick();
        total++;
        if (n_dv + n_pef + n_se + n_sg + n_pce !== 0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_quiet: got strobes=%0d busy=%b want 0 0",
                            n_dv + n_pef + n_se + n_sg + n_pce, bus.busy);
        end
        total++;
        if (n_multi !== 0) begin
            bad++; $display("FAIL exclusive_strobes: got %0d want 0", n_multi);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        mon_en = 1'b0;
        par_pending = 1'b0;
        n_multi = 0;
        clear_counts();
        test_reset();
        test_parity_ok();
        test_no_parity();
        test_parity_err();
        test_stop_err();
        test_start_glitch();
        test_majority();
        test_back_to_back();
        test_prescale_default();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
